// File: rtl/conv_row_extend.sv
// Horizontal border extension: widens each raster row by R pad pixels per side,
// padding with zeros or a copy of the row's edge pixel.
package cfg_pkg;
    localparam string EXTEND_STRATEGY = "ZERO_PAD";
endpackage

module conv_row_extend #(
    parameter int    W               = 8,
    parameter int    R               = 1,
    parameter string EXTEND_STRATEGY = cfg_pkg::EXTEND_STRATEGY
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         i_vld,
    output logic         i_rdy,
    input  logic [W-1:0] i_dat,
    input  logic         i_sol,
    input  logic         i_eol,
    output logic         o_vld,
    input  logic         o_rdy,
    output logic [W-1:0] o_dat,
    output logic         o_sol,
    output logic         o_eol,
    output logic         o_err
);

    localparam int CW = $clog2(R + 1);
    localparam bit REPL = (EXTEND_STRATEGY == "REPLICATE");
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_R    = CW'(R);
    localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

    generate
        if (EXTEND_STRATEGY != "ZERO_PAD" && EXTEND_STRATEGY != "REPLICATE") begin : g_bad_strategy
            $error("conv_row_extend: EXTEND_STRATEGY must be ZERO_PAD or REPLICATE");
        end
        if (R < 1 || R > 15) begin : g_bad_radius
            $error("conv_row_extend: R must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LEFT, BODY, RIGHT} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   hold_dat_q;
    logic           hold_eol_q;
    logic           o_vld_q, o_sol_q, o_eol_q, o_err_q;
    logic [W-1:0]   o_dat_q;

    logic           slot;
    logic [W-1:0]   pad;

    assign slot  = !o_vld_q || o_rdy;
    assign i_rdy = slot && (state_q == IDLE || state_q == BODY);
    // hold tracks the first pixel while padding left and the latest pixel while padding right
    assign pad   = REPL ? hold_dat_q : '0;

    assign o_vld = o_vld_q;
    assign o_dat = o_dat_q;
    assign o_sol = o_sol_q;
    assign o_eol = o_eol_q;
    assign o_err = o_err_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hold_dat_q <= '0;
            hold_eol_q <= 1'b0;
            o_vld_q    <= 1'b0;
            o_dat_q    <= '0;
            o_sol_q    <= 1'b0;
            o_eol_q    <= 1'b0;
            o_err_q    <= 1'b0;
        end else begin
            o_err_q <= 1'b0;
            if (slot) begin
                o_vld_q <= 1'b0;
                o_sol_q <= 1'b0;
                o_eol_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (i_vld) begin
                            if (i_sol) begin
                                hold_dat_q <= i_dat;
                                hold_eol_q <= i_eol;
                                o_vld_q    <= 1'b1;
                                o_sol_q    <= 1'b1;
                                o_dat_q    <= REPL ? i_dat : '0;
                                cnt_q      <= CNT_ONE;
                                state_q    <= LEFT;
                            end else begin
                                o_err_q <= 1'b1;
                            end
                        end
                    end
                    LEFT: begin
                        o_vld_q <= 1'b1;
                        if (cnt_q < CNT_R) begin
                            o_dat_q <= pad;
                            cnt_q   <= cnt_q + CNT_ONE;
                        end else begin
                            o_dat_q <= hold_dat_q;
                            if (hold_eol_q) begin
                                cnt_q   <= '0;
                                state_q <= RIGHT;
                            end else begin
                                state_q <= BODY;
                            end
                        end
                    end
                    BODY: begin
                        if (i_vld) begin
                            o_vld_q    <= 1'b1;
                            o_dat_q    <= i_dat;
                            hold_dat_q <= i_dat;
                            if (i_sol) o_err_q <= 1'b1;
                            if (i_eol) begin
                                cnt_q   <= '0;
                                state_q <= RIGHT;
                            end
                        end
                    end
                    RIGHT: begin
                        o_vld_q <= 1'b1;
                        o_dat_q <= pad;
                        cnt_q   <= cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            o_eol_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv_row_extend.sv
// Scoreboard bench for conv_row_extend: three configurations (ZERO_PAD R=1,
// REPLICATE R=2, REPLICATE R=1 under random backpressure) checked by a shared monitor.
module tb_conv_row_extend;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic arst_n;
    logic [ND-1:0]      i_vld, i_rdy, i_sol, i_eol, o_vld, o_rdy, o_sol, o_eol, o_err;
    logic [ND-1:0][7:0] i_dat, o_dat;

    always #5 clk = ~clk;

    conv_row_extend #(.W(8), .R(1), .EXTEND_STRATEGY("ZERO_PAD")) u_zp1 (
        .clk(clk), .arst_n(arst_n), .i_vld(i_vld[0]), .i_rdy(i_rdy[0]), .i_dat(i_dat[0]),
        .i_sol(i_sol[0]), .i_eol(i_eol[0]), .o_vld(o_vld[0]), .o_rdy(o_rdy[0]),
        .o_dat(o_dat[0]), .o_sol(o_sol[0]), .o_eol(o_eol[0]), .o_err(o_err[0]));
    conv_row_extend #(.W(8), .R(2), .EXTEND_STRATEGY("REPLICATE")) u_rp2 (
        .clk(clk), .arst_n(arst_n), .i_vld(i_vld[1]), .i_rdy(i_rdy[1]), .i_dat(i_dat[1]),
        .i_sol(i_sol[1]), .i_eol(i_eol[1]), .o_vld(o_vld[1]), .o_rdy(o_rdy[1]),
        .o_dat(o_dat[1]), .o_sol(o_sol[1]), .o_eol(o_eol[1]), .o_err(o_err[1]));
    conv_row_extend #(.W(8), .R(1), .EXTEND_STRATEGY("REPLICATE")) u_rp1 (
        .clk(clk), .arst_n(arst_n), .i_vld(i_vld[2]), .i_rdy(i_rdy[2]), .i_dat(i_dat[2]),
        .i_sol(i_sol[2]), .i_eol(i_eol[2]), .o_vld(o_vld[2]), .o_rdy(o_rdy[2]),
        .o_dat(o_dat[2]), .o_sol(o_sol[2]), .o_eol(o_eol[2]), .o_err(o_err[2]));

    typedef struct packed {
        logic [7:0] dat;
        logic       sol;
        logic       eol;
    } beat_t;

    beat_t q0[$], q1[$], q2[$];
    int    checks = 0, failures = 0;
    int    err_cnt[ND], beat_cnt[ND], sol_cnt[ND], eol_cnt[ND];
    int    rdy_low = 0, stalls2 = 0;
    bit    rdy_win = 0, rnd_en = 0;
    logic [7:0] sq[$];
    logic [7:0] eq[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void push(int d, logic [7:0] dat, logic sol, logic eol);
        beat_t b;
        b.dat = dat; b.sol = sol; b.eol = eol;
        case (d)
            0: q0.push_back(b);
            1: q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endfunction

    function automatic int qsize(int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic beat_t qpop(int d);
        case (d)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: pops on every accepted output beat and checks hold-stability under backpressure
    initial begin
        beat_t       prev[ND];
        logic [ND-1:0] stall_q = '0;
        for (int d = 0; d < ND; d++) begin
            err_cnt[d] = 0; beat_cnt[d] = 0; sol_cnt[d] = 0; eol_cnt[d] = 0;
            prev[d] = '0;
        end
        forever begin
            @(negedge clk);
            if (rdy_win && !i_rdy[0]) rdy_low++;
            for (int d = 0; d < ND; d++) begin
                beat_t cur;
                cur.dat = o_dat[d]; cur.sol = o_sol[d]; cur.eol = o_eol[d];
                if (!arst_n) stall_q[d] = 1'b0;
                if (stall_q[d])
                    check($sformatf("hold_stable_dut%0d", d), 32'({o_vld[d], cur}), 32'({1'b1, prev[d]}));
                if (o_err[d]) err_cnt[d]++;
                if (o_vld[d] && o_rdy[d]) begin
                    beat_cnt[d]++;
                    if (o_sol[d]) sol_cnt[d]++;
                    if (o_eol[d]) eol_cnt[d]++;
                    if (qsize(d) == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_beat_dut%0d: got beat %0h expected none", d, cur);
                    end else begin
                        beat_t e;
                        e = qpop(d);
                        check($sformatf("beat_dut%0d", d), 32'(cur), 32'(e));
                    end
                end
                stall_q[d] = o_vld[d] && !o_rdy[d] && arst_n;
                if (d == 2 && stall_q[d]) stalls2++;
                prev[d] = cur;
            end
        end
    end

    // o_rdy: held high, except the REPLICATE R=1 instance under a random pattern when enabled
    initial begin
        o_rdy = '1;
        forever begin
            @(posedge clk);
            #1;
            o_rdy = {rnd_en ? 1'($urandom_range(0, 1)) : 1'b1, 2'b11};
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pix(int d, logic [7:0] dat, logic sol, logic eol);
        int n = 0;
        i_vld[d] = 1'b1; i_dat[d] = dat; i_sol[d] = sol; i_eol[d] = eol;
        do begin
            @(negedge clk);
            n++;
        end while (!i_rdy[d] && n < 200);
        if (!i_rdy[d]) begin
            checks++; failures++;
            $display("FAIL input_timeout_dut%0d: i_rdy got 0 expected 1", d);
        end
        @(posedge clk);
        #1;
        i_vld[d] = 1'b0; i_sol[d] = 1'b0; i_eol[d] = 1'b0;
    endtask

    task automatic send_row(int d);
        for (int k = 0; k < sq.size(); k++)
            send_pix(d, sq[k], k == 0, k == sq.size() - 1);
    endtask

    task automatic expect_row(int d);
        for (int k = 0; k < eq.size(); k++)
            push(d, eq[k], k == 0, k == eq.size() - 1);
    endtask

    task automatic drain(string name);
        int n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check({name, "_left_q0"}, 32'(q0.size()), 32'd0);
        check({name, "_left_q1"}, 32'(q1.size()), 32'd0);
        check({name, "_left_q2"}, 32'(q2.size()), 32'd0);
    endtask

    initial begin
        int    b0, s0, e0, r0;
        longint t0;
        i_vld = '0; i_sol = '0; i_eol = '0; i_dat = '0;
        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ctrl_outs", 32'({o_vld, o_sol, o_eol, o_err}), 32'd0);
        check("reset_dat", 32'(o_dat), 32'd0);
        check("reset_i_rdy", 32'(i_rdy), 32'h7);
        #1 arst_n = 1'b1;

        // ZERO_PAD R=1 basic row
        sync();
        sq = '{8'd10, 8'd20, 8'd30, 8'd40};
        eq = '{8'd0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd0};
        expect_row(0);
        rdy_win = 1;
        send_row(0);
        repeat (6) @(negedge clk);
        rdy_win = 0;
        check("zp1_irdy_low_cycles", 32'(rdy_low), 32'd2);
        drain("zp1_row");

        // REPLICATE R=2, then a 1-pixel row
        sync();
        sq = '{8'd10, 8'd20, 8'd30, 8'd40};
        eq = '{8'd10, 8'd10, 8'd10, 8'd20, 8'd30, 8'd40, 8'd40, 8'd40};
        expect_row(1);
        send_row(1);
        sq = '{8'd7};
        eq = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
        expect_row(1);
        send_row(1);
        drain("rp2_rows");

        // REPLICATE R=1 under random backpressure, back-to-back rows
        rnd_en = 1;
        sync();
        sq = '{8'd1, 8'd2, 8'd3};  eq = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd3};  expect_row(2); send_row(2);
        sq = '{8'd9};              eq = '{8'd9, 8'd9, 8'd9};              expect_row(2); send_row(2);
        sq = '{8'd4, 8'd5};        eq = '{8'd4, 8'd4, 8'd5, 8'd5};        expect_row(2); send_row(2);
        drain("rp1_bp");
        rnd_en = 0;
        check("rp1_bp_stalls_seen", 32'(stalls2 > 0), 32'd1);

        // Protocol errors: stray pixel in IDLE, then sol inside a row body
        e0 = err_cnt[0]; b0 = beat_cnt[0];
        sync();
        send_pix(0, 8'd5, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("err_idle_pulse", 32'(err_cnt[0] - e0), 32'd1);
        check("err_idle_no_beat", 32'(beat_cnt[0] - b0), 32'd0);
        sync();
        sq = '{8'd6, 8'd8};
        eq = '{8'd0, 8'd6, 8'd8, 8'd0};
        expect_row(0);
        send_row(0);
        eq = '{8'd0, 8'd11, 8'd12, 8'd13, 8'd0};
        expect_row(0);
        send_pix(0, 8'd11, 1'b1, 1'b0);
        send_pix(0, 8'd12, 1'b1, 1'b0);
        send_pix(0, 8'd13, 1'b0, 1'b1);
        drain("err_rows");
        check("err_total_pulses", 32'(err_cnt[0] - e0), 32'd2);

        // Reset in the middle of a row
        sync();
        push(0, 8'd0, 1'b1, 1'b0);
        push(0, 8'd10, 1'b0, 1'b0);
        push(0, 8'd20, 1'b0, 1'b0);
        push(0, 8'd30, 1'b0, 1'b0);
        send_pix(0, 8'd10, 1'b1, 1'b0);
        send_pix(0, 8'd20, 1'b0, 1'b0);
        send_pix(0, 8'd30, 1'b0, 1'b0);
        @(negedge clk);
        #1 arst_n = 1'b0;
        #1;
        check("midrst_beats_before", 32'(q0.size()), 32'd0);
        check("midrst_ctrl_outs", 32'({o_vld, o_sol, o_eol, o_err}), 32'd0);
        check("midrst_dat", 32'(o_dat), 32'd0);
        check("midrst_i_rdy", 32'(i_rdy), 32'h7);
        repeat (2) @(negedge clk);
        check("midrst_vld_held", 32'(o_vld), 32'd0);
        #1 arst_n = 1'b1;
        sync();
        sq = '{8'd1, 8'd2, 8'd3};
        eq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
        expect_row(0);
        send_row(0);
        drain("midrst_next_row");

        // Sustained streaming: 100 rows of 16 pixels
        b0 = beat_cnt[0]; s0 = sol_cnt[0]; e0 = eol_cnt[0]; r0 = err_cnt[0];
        sync();
        t0 = $time;
        for (int r = 0; r < 100; r++) begin
            sq.delete();
            eq.delete();
            eq.push_back(8'd0);
            for (int k = 0; k < 16; k++) begin
                sq.push_back(8'(r * 7 + k + 1));
                eq.push_back(8'(r * 7 + k + 1));
            end
            eq.push_back(8'd0);
            expect_row(0);
            send_row(0);
        end
        check("sust_cycles_to_last_accept", 32'(($time - t0) / 10), 32'd1799);
        drain("sustained");
        check("sust_beats", 32'(beat_cnt[0] - b0), 32'd1800);
        check("sust_sols", 32'(sol_cnt[0] - s0), 32'd100);
        check("sust_eols", 32'(eol_cnt[0] - e0), 32'd100);
        check("sust_no_err", 32'(err_cnt[0] - r0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
